// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

  // Architectural register select.
  typedef logic [4:0] regbits_t;

  // Sequencer states: normal flow, data-memory wait, sticky halt.
  typedef enum logic [1:0] {
    PC_RUN   = 2'd0,
    PC_DWAIT = 2'd1,
    PC_HALT  = 2'd2
  } pctrl_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detect: the load in EX targets a register the DC instruction reads.
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic     ex_d_ren_i,
  input  regbits_t ex_wsel_i,
  input  regbits_t dc_rsel1_i,
  input  regbits_t dc_rsel2_i,
  input  logic     dc_uses_rt_i,
  output logic     lu_o
);

  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  always_comb begin
    lu_o = ex_d_ren_i && (ex_wsel_i != '0) &&
           ((ex_wsel_i == dc_rsel1_i) || (dc_uses_rt_i && (ex_wsel_i == dc_rsel2_i)));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Optional perf counters (stall_cnt, flush_cnt) enabled by PIPE_CTRL_PERF_EN.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned DWAIT_MAX = 64,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dreq,
  input  logic             mem_halt,
  input  logic             branch_taken,
  input  logic             ex_d_ren,
  input  regbits_t         ex_wsel,
  input  regbits_t         dc_rsel1,
  input  regbits_t         dc_rsel2,
  input  logic             dc_uses_rt,
  output logic             pc_en,
  output logic             pipe1_en,
  output logic             pipe2_en,
  output logic             pipe3_en,
  output logic             pipe4_en,
  output logic             flushed1,
  output logic             flushed2,
  output logic             flushed3,
  output logic             flushed4,
  output logic             halt,
  output logic             mem_timeout
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int unsigned WaitW = (DWAIT_MAX > 2) ? $clog2(DWAIT_MAX) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(DWAIT_MAX - 1);

  pctrl_state_t     state_q, state_d;
  logic             halt_q, halt_d;
  logic             tmo_q, tmo_d;
  logic [WaitW-1:0] wcnt_q, wcnt_d;
  logic [3:0]       pipe_en, flushed;
  logic             dwait, lu;

  assign dwait = mem_dreq & ~dhit;

  load_use_detect u_lu (
    .ex_d_ren_i   (ex_d_ren),
    .ex_wsel_i    (ex_wsel),
    .dc_rsel1_i   (dc_rsel1),
    .dc_rsel2_i   (dc_rsel2),
    .dc_uses_rt_i (dc_uses_rt),
    .lu_o         (lu)
  );

  // Per-cycle priority decision and next-state for the FSM and wait counter.
  always_comb begin
    pc_en   = 1'b0;
    pipe_en = '0;
    flushed = '0;
    state_d = state_q;
    halt_d  = halt_q;
    tmo_d   = tmo_q;
    wcnt_d  = wcnt_q;
    if (state_q == PC_HALT) begin
      // Frozen until reset.
    end else if (mem_halt) begin
      pipe_en[3] = 1'b1;
      flushed[2] = 1'b1;
      state_d    = PC_HALT;
      halt_d     = 1'b1;
      wcnt_d     = '0;
    end else if (dwait) begin
      state_d = PC_DWAIT;
      if (state_q == PC_DWAIT) begin
        if (wcnt_q != WaitLast) wcnt_d = wcnt_q + 1'b1;
        if (wcnt_d == WaitLast) tmo_d = 1'b1;
      end
    end else begin
      state_d = PC_RUN;
      wcnt_d  = '0;
      if (branch_taken) begin
        pc_en      = 1'b1;
        flushed    = 4'b0111;
        pipe_en[3] = 1'b1;
      end else if (lu) begin
        flushed[1] = 1'b1;
        pipe_en    = 4'b1100;
      end else if (!ihit) begin
        flushed[0] = 1'b1;
        pipe_en    = 4'b1110;
      end else begin
        pc_en   = 1'b1;
        pipe_en = 4'b1111;
      end
    end
    // Hold everything in bubbles while reset is asserted.
    if (!nRST) begin
      pc_en   = 1'b0;
      pipe_en = '0;
      flushed = '1;
    end
  end

  // Sequencer state, sticky flags and wait counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= PC_RUN;
      halt_q  <= 1'b0;
      tmo_q   <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
      tmo_q   <= tmo_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign pipe1_en    = pipe_en[0];
  assign pipe2_en    = pipe_en[1];
  assign pipe3_en    = pipe_en[2];
  assign pipe4_en    = pipe_en[3];
  assign flushed1    = flushed[0];
  assign flushed2    = flushed[1];
  assign flushed3    = flushed[2];
  assign flushed4    = flushed[3];
  assign halt        = halt_q;
  assign mem_timeout = tmo_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  // Perf counters wrap naturally at 2^CNT_W.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_en && (state_q != PC_HALT)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flushed[1] || flushed[2]) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // Perf counter registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (DWAIT_MAX=4).
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  logic CLK = 1'b0;
  logic nRST, ihit, dhit, mem_dreq, mem_halt, branch_taken, ex_d_ren, dc_uses_rt;
  regbits_t ex_wsel, dc_rsel1, dc_rsel2;
  logic pc_en, pipe1_en, pipe2_en, pipe3_en, pipe4_en;
  logic flushed1, flushed2, flushed3, flushed4, halt, mem_timeout;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  // {pc_en, pipe1..4_en, flushed1..4}
  logic [8:0] ctl;
  assign ctl = {pc_en, pipe1_en, pipe2_en, pipe3_en, pipe4_en,
                flushed1, flushed2, flushed3, flushed4};

  localparam logic [8:0] CtlRst  = 9'b0_0000_1111;
  localparam logic [8:0] CtlRun  = 9'b1_1111_0000;
  localparam logic [8:0] CtlLu   = 9'b0_0011_0100;
  localparam logic [8:0] CtlImis = 9'b0_0111_1000;
  localparam logic [8:0] CtlFrz  = 9'b0_0000_0000;
  localparam logic [8:0] CtlBr   = 9'b1_0001_1110;
  localparam logic [8:0] CtlHalt = 9'b0_0001_0010;

  always #5 CLK = ~CLK;

  pipeline_ctrl #(.DWAIT_MAX(4), .CNT_W(32)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .ihit         (ihit),
    .dhit         (dhit),
    .mem_dreq     (mem_dreq),
    .mem_halt     (mem_halt),
    .branch_taken (branch_taken),
    .ex_d_ren     (ex_d_ren),
    .ex_wsel      (ex_wsel),
    .dc_rsel1     (dc_rsel1),
    .dc_rsel2     (dc_rsel2),
    .dc_uses_rt   (dc_uses_rt),
    .pc_en        (pc_en),
    .pipe1_en     (pipe1_en),
    .pipe2_en     (pipe2_en),
    .pipe3_en     (pipe3_en),
    .pipe4_en     (pipe4_en),
    .flushed1     (flushed1),
    .flushed2     (flushed2),
    .flushed3     (flushed3),
    .flushed4     (flushed4),
    .halt         (halt),
    .mem_timeout  (mem_timeout)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  task automatic idle_inputs();
    ihit = 1'b1; dhit = 1'b0; mem_dreq = 1'b0; mem_halt = 1'b0; branch_taken = 1'b0;
    ex_d_ren = 1'b0; ex_wsel = '0; dc_rsel1 = '0; dc_rsel2 = '0; dc_uses_rt = 1'b0;
  endtask

  // Advance one edge; sample 1 time unit after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_reset();
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    nRST = 1'b0;
    #3;
    total_cnt++;
    if (ctl !== CtlRst) $display("FAIL reset_ctl got=%b want=%b", ctl, CtlRst);
    else pass_cnt++;
    total_cnt++;
    if ({halt, mem_timeout} !== 2'b00)
      $display("FAIL reset_flags got=%b want=00", {halt, mem_timeout});
    else pass_cnt++;
    step();
    nRST = 1'b1;
    #1;
    total_cnt++;
    if (ctl !== CtlRun) $display("FAIL run_ctl got=%b want=%b", ctl, CtlRun);
    else pass_cnt++;
  endtask

  task automatic test_load_use();
    ex_d_ren = 1'b1; ex_wsel = 5'd5; dc_rsel1 = 5'd5; dc_rsel2 = 5'd9;
    #1;
    total_cnt++;
    if (ctl !== CtlLu) $display("FAIL lu_rs got=%b want=%b", ctl, CtlLu);
    else pass_cnt++;
    dc_rsel1 = 5'd7; dc_rsel2 = 5'd5; dc_uses_rt = 1'b0;
    #1;
    total_cnt++;
    if (ctl !== CtlRun) $display("FAIL lu_rt_unused got=%b want=%b", ctl, CtlRun);
    else pass_cnt++;
    dc_uses_rt = 1'b1;
    #1;
    total_cnt++;
    if (ctl !== CtlLu) $display("FAIL lu_rt got=%b want=%b", ctl, CtlLu);
    else pass_cnt++;
    ex_wsel = 5'd0; dc_rsel1 = 5'd0; dc_rsel2 = 5'd0;
    #1;
    total_cnt++;
    if (ctl !== CtlRun) $display("FAIL lu_r0 got=%b want=%b", ctl, CtlRun);
    else pass_cnt++;
    step();
    idle_inputs();
  endtask

  task automatic test_dwait();
    mem_dreq = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++;
      if (ctl !== CtlFrz) $display("FAIL dwait_freeze%0d got=%b want=%b", i, ctl, CtlFrz);
      else pass_cnt++;
      step();
    end
    // Completion cycle with an I-miss: MEM retires, front stalls.
    dhit = 1'b1; ihit = 1'b0;
    #1;
    total_cnt++;
    if (ctl !== CtlImis) $display("FAIL dwait_done got=%b want=%b", ctl, CtlImis);
    else pass_cnt++;
    step();
    mem_dreq = 1'b0; dhit = 1'b0; ihit = 1'b1;
    #1;
    total_cnt++;
    if (ctl !== CtlRun) $display("FAIL dwait_back_run got=%b want=%b", ctl, CtlRun);
    else pass_cnt++;
    total_cnt++;
    if (mem_timeout !== 1'b0) $display("FAIL dwait_no_tmo got=%b want=0", mem_timeout);
    else pass_cnt++;
    step();
  endtask

  task automatic test_timeout();
    mem_dreq = 1'b1; dhit = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      total_cnt++;
      if (mem_timeout !== (i >= 4))
        $display("FAIL tmo_edge%0d got=%b want=%b", i, mem_timeout, (i >= 4));
      else pass_cnt++;
    end
    total_cnt++;
    if (ctl !== CtlFrz) $display("FAIL tmo_freeze got=%b want=%b", ctl, CtlFrz);
    else pass_cnt++;
    mem_dreq = 1'b0;
    step();
    total_cnt++;
    if (mem_timeout !== 1'b1) $display("FAIL tmo_sticky got=%b want=1", mem_timeout);
    else pass_cnt++;
    pulse_reset();
    total_cnt++;
    if (mem_timeout !== 1'b0) $display("FAIL tmo_reset got=%b want=0", mem_timeout);
    else pass_cnt++;
  endtask

  task automatic test_branch_lu();
    branch_taken = 1'b1; ex_d_ren = 1'b1; ex_wsel = 5'd3; dc_rsel1 = 5'd3;
    #1;
    total_cnt++;
    if (ctl !== CtlBr) $display("FAIL branch_lu got=%b want=%b", ctl, CtlBr);
    else pass_cnt++;
    step();
    idle_inputs();
  endtask

  task automatic test_halt();
    mem_halt = 1'b1; mem_dreq = 1'b1; dhit = 1'b0;
    #1;
    total_cnt++;
    if (ctl !== CtlHalt) $display("FAIL halt_cycle got=%b want=%b", ctl, CtlHalt);
    else pass_cnt++;
    step();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if ({halt, ctl} !== {1'b1, CtlFrz})
        $display("FAIL halted%0d got=%b want=%b", i, {halt, ctl}, {1'b1, CtlFrz});
      else pass_cnt++;
      step();
    end
    pulse_reset();
    total_cnt++;
    if ({halt, ctl} !== {1'b0, CtlRun})
      $display("FAIL halt_reset got=%b want=%b", {halt, ctl}, {1'b0, CtlRun});
    else pass_cnt++;
  endtask

`ifdef PIPE_CTRL_PERF_EN
  task automatic test_imiss_perf();
    pulse_reset();
    ihit = 1'b0;
    #1;
    total_cnt++;
    if (ctl !== CtlImis) $display("FAIL imiss_ctl got=%b want=%b", ctl, CtlImis);
    else pass_cnt++;
    step();
    step();
    ihit = 1'b1;
    #1;
    total_cnt++;
    if (stall_cnt !== 32'd2) $display("FAIL stall_cnt got=%0d want=2", stall_cnt);
    else pass_cnt++;
    total_cnt++;
    if (flush_cnt !== 32'd0) $display("FAIL flush_cnt got=%0d want=0", flush_cnt);
    else pass_cnt++;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_dwait();
    test_timeout();
    test_branch_lu();
    test_halt();
`ifdef PIPE_CTRL_PERF_EN
    test_imiss_perf();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
